// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. One full-adder cell processes one bit per
// clock, LSB first; a WIDTH-bit addition takes WIDTH RUN cycles followed by a
// one-cycle DONE state that presents the result with a done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (two's complement: ~b plus a forced carry of 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Operand B and initial carry as loaded on an accepted start.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: a + ~b + 1; the incoming cin is ignored in that mode.
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    // Add-only build: operands pass straight through.
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Full-adder cell on the current LSBs and the result shift register
    // with the new bit inserted at the MSB (written so WIDTH=1 is legal).
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] s_shift;

    always_comb begin
        bit_s   = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        bit_c   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
        s_shift = s_sr_q >> 1;
        s_shift[WIDTH-1] = bit_s;
    end

    // Next-state logic: start is only honoured outside RUN, and the published
    // result registers move only on the final RUN cycle.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    c_d     = c_load;
                    s_sr_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = bit_c;
                s_sr_d = s_shift;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = s_shift;
                    cout_d  = bit_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: a WIDTH=8 instance and a WIDTH=1 instance, each
// tracked by a cycle-level behavioural model that computes results with plain
// integer addition. Directed cases pin the model to literal values.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8 = 1'b0;
    logic       sub1 = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation accepted while not busy computes its
    // result immediately as an integer sum, then reveals it WIDTH edges later.
    bit        m8_busy = 0, m8_done = 0, m8_cout = 0;
    bit [7:0]  m8_sum = 0;
    bit [8:0]  m8_res = 0;
    int        m8_left = 0;
    bit        m1_busy = 0, m1_done = 0, m1_cout = 0;
    bit [0:0]  m1_sum = 0;
    bit [1:0]  m1_res = 0;
    int        m1_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m8_busy = 0; m8_done = 0; m8_sum = 0; m8_cout = 0; m8_left = 0;
        end else if (m8_busy) begin
            m8_done = 0;
            m8_left--;
            if (m8_left == 0) begin
                m8_busy = 0;
                m8_done = 1;
                {m8_cout, m8_sum} = m8_res;
            end
        end else if (start8) begin
            m8_res = 9'(a8) + 9'(b8) + 9'(cin8);
`ifdef SERIAL_ADDER_SUB_EN
            if (sub8) m8_res = 9'(a8) + 9'(8'(~b8)) + 9'd1;
`endif
            m8_busy = 1; m8_done = 0; m8_left = 8;
        end else begin
            m8_done = 0;
        end

        if (rst) begin
            m1_busy = 0; m1_done = 0; m1_sum = 0; m1_cout = 0; m1_left = 0;
        end else if (m1_busy) begin
            m1_done = 0;
            m1_left--;
            if (m1_left == 0) begin
                m1_busy = 0;
                m1_done = 1;
                {m1_cout, m1_sum} = m1_res;
            end
        end else if (start1) begin
            m1_res = 2'(a1) + 2'(b1) + 2'(cin1);
`ifdef SERIAL_ADDER_SUB_EN
            if (sub1) m1_res = 2'(a1) + 2'(1'(~b1)) + 2'd1;
`endif
            m1_busy = 1; m1_done = 0; m1_left = 1;
        end else begin
            m1_done = 0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", 64'(busy8), 64'(m8_busy));
            check("done8", 64'(done8), 64'(m8_done));
            check("sum8",  64'(sum8),  64'(m8_sum));
            check("cout8", 64'(cout8), 64'(m8_cout));
            check("busy1", 64'(busy1), 64'(m1_busy));
            check("done1", 64'(done1), 64'(m1_done));
            check("sum1",  64'(sum1),  64'(m1_sum));
            check("cout1", 64'(cout1), 64'(m1_cout));
        end
    end

    // Wait (bounded) at negedges for done8; a timeout is a failed check.
    task automatic wait_done8(input string name);
        for (int i = 0; i < 30; i++) begin
            if (done8 === 1'b1) break;
            @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(done8), 64'd1);
    endtask

    // Launch one WIDTH=8 operation, wait for done and pin DUT and model to literals.
    task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic [7:0] es, input logic ec);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(name);
        $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", name, av, bv, cv, sum8, cout8);
        check({name, "_sum"},  64'(sum8),   64'(es));
        check({name, "_cout"}, 64'(cout8),  64'(ec));
        check({name, "_msum"}, 64'(m8_sum), 64'(es));
    endtask

    initial begin
        bit [7:0] tt_sum  = 8'b1001_0110;
        bit [7:0] tt_cout = 8'b1110_1000;

        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 64'(busy8), 64'd0);
        check("reset_sum",  64'(sum8),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        op8("basic",  8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        op8("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start during RUN (edge E0+3) with new operands must be ignored.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'hBB;
        wait_done8("ignore");
        check("ignore_sum", 64'(sum8), 64'h46);
        repeat (10) @(negedge clk);

        // Back-to-back with start held high through DONE.
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20;
        wait_done8("b2b_first");
        check("b2b_first_sum", 64'(sum8), 64'h8D);
        @(negedge clk);
        check("b2b_rebusy", 64'(busy8), 64'd1);
        start8 = 1'b0;
        wait_done8("b2b_second");
        check("b2b_second_sum", 64'(sum8), 64'h30);

        // Reset in the middle of an operation, at edge E0+4.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_sum",  64'(sum8),  64'd0);
        repeat (12) @(negedge clk);
        op8("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b1;
        op8("sub1", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        op8("sub2", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        sub8 = 1'b0;
`endif

        // WIDTH=1 exhaustive against the full-adder truth table.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            @(negedge clk);
            start1 = 1'b0;
            @(negedge clk);
            $display("w1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", a1, b1, cin1, sum1, cout1);
            check("w1_done", 64'(done1), 64'd1);
            check("w1_sum",  64'(sum1),  64'(tt_sum[v]));
            check("w1_cout", 64'(cout1), 64'(tt_cout[v]));
        end

        // Random traffic on both instances, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 2) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start1 = ($urandom_range(0, 1) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            rst = ($urandom_range(0, 120) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
